// File: rtl/mesi_isc_snoop_sched.sv
// rtl/mesi_isc_snoop_sched.sv - MESI coherence snoop scheduler for four CPUs
//
// Purpose: picks one main-bus request at a time, round-robin. Plain WR/RD
// requests are only acknowledged. Broadcast requests go on to snoop the other
// three ports, then enable the requester.
//
// Ports:
//   clk, rst                 clock and synchronous active-low reset
//   mbus_cmd*_i, mbus_addr*_i  per-CPU main-bus command and address
//   cbus_ack*_i              per-CPU coherence acknowledge
//   mbus_ack*_o              one-cycle grant pulse to the chosen CPU
//   cbus_cmd*_o              per-CPU coherence command
//   cbus_addr_o, grant_id_o  address and id of the transaction in service
//   busy_o, err_o            not-idle flag and sticky timeout flag
module mesi_isc_snoop_sched #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd3_i,
  input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd2_i,
  input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd1_i,
  input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd0_i,
  input  logic [ADDR_WIDTH-1:0]     mbus_addr3_i,
  input  logic [ADDR_WIDTH-1:0]     mbus_addr2_i,
  input  logic [ADDR_WIDTH-1:0]     mbus_addr1_i,
  input  logic [ADDR_WIDTH-1:0]     mbus_addr0_i,
  input  logic                      cbus_ack3_i,
  input  logic                      cbus_ack2_i,
  input  logic                      cbus_ack1_i,
  input  logic                      cbus_ack0_i,
  output logic                      mbus_ack3_o,
  output logic                      mbus_ack2_o,
  output logic                      mbus_ack1_o,
  output logic                      mbus_ack0_o,
  output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd3_o,
  output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd2_o,
  output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd1_o,
  output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd0_o,
  output logic [ADDR_WIDTH-1:0]     cbus_addr_o,
  output logic [1:0]                grant_id_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam logic [MBUS_CMD_WIDTH-1:0] M_WR       = MBUS_CMD_WIDTH'(1);
  localparam logic [MBUS_CMD_WIDTH-1:0] M_RD       = MBUS_CMD_WIDTH'(2);
  localparam logic [MBUS_CMD_WIDTH-1:0] M_WR_BROAD = MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0] M_RD_BROAD = MBUS_CMD_WIDTH'(4);

  localparam logic [CBUS_CMD_WIDTH-1:0] C_NOP      = CBUS_CMD_WIDTH'(0);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_EN_RD    = CBUS_CMD_WIDTH'(4);

  // Leaving on the edge where the count would reach TIMEOUT gives exactly
  // TIMEOUT cycles in a wait phase.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACK, SNOOP, ENABLE} state_t;

  state_t                    state;
  logic [1:0]                id;
  logic [1:0]                rr_ptr;
  logic [MBUS_CMD_WIDTH-1:0] cmd;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [3:0]                ack_seen;
  logic [7:0]                cnt;
  logic                      err;

  logic [MBUS_CMD_WIDTH-1:0] req_cmd  [4];
  logic [ADDR_WIDTH-1:0]     req_addr [4];
  logic [3:0]                req_valid;
  logic [3:0]                cack;
  logic [3:0]                id_mask;
  logic                      win_found;
  logic [1:0]                win_id;
  logic [1:0]                idx;
  logic                      others_done;

  assign req_cmd[0]  = mbus_cmd0_i;
  assign req_cmd[1]  = mbus_cmd1_i;
  assign req_cmd[2]  = mbus_cmd2_i;
  assign req_cmd[3]  = mbus_cmd3_i;
  assign req_addr[0] = mbus_addr0_i;
  assign req_addr[1] = mbus_addr1_i;
  assign req_addr[2] = mbus_addr2_i;
  assign req_addr[3] = mbus_addr3_i;
  assign cack        = {cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i};
  assign id_mask     = 4'b0001 << id;

  // The requester's bit is forced set so its own ack never matters here.
  assign others_done = &(ack_seen | cack | id_mask);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (req_cmd[i] == M_WR) || (req_cmd[i] == M_RD) ||
                     (req_cmd[i] == M_WR_BROAD) || (req_cmd[i] == M_RD_BROAD);
    end
  end

  // Scan offsets high to low so the valid port closest to rr_ptr wins last.
  always_comb begin
    win_found = 1'b0;
    win_id    = rr_ptr;
    idx       = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      id       <= 2'd0;
      rr_ptr   <= 2'd0;
      cmd      <= '0;
      addr     <= '0;
      ack_seen <= 4'd0;
      cnt      <= 8'd0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            id    <= win_id;
            cmd   <= req_cmd[win_id];
            addr  <= req_addr[win_id];
            state <= ACK;
          end
        end
        ACK: begin
          if (cmd == M_WR_BROAD || cmd == M_RD_BROAD) begin
            ack_seen <= 4'd0;
            cnt      <= 8'd0;
            state    <= SNOOP;
          end else begin
            rr_ptr <= id + 2'd1;
            state  <= IDLE;
          end
        end
        SNOOP: begin
          ack_seen <= ack_seen | (cack & ~id_mask);
          if (others_done) begin
            cnt   <= 8'd0;
            state <= ENABLE;
          end else if (cnt == CNT_LAST) begin
            err    <= 1'b1;
            rr_ptr <= id + 2'd1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ENABLE: begin
          if (cack[id]) begin
            rr_ptr <= id + 2'd1;
            state  <= IDLE;
          end else if (cnt == CNT_LAST) begin
            err    <= 1'b1;
            rr_ptr <= id + 2'd1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from registers only.
  logic [CBUS_CMD_WIDTH-1:0] ccmd [4];
  logic [3:0]                mack;

  always_comb begin
    mack = (state == ACK) ? id_mask : 4'd0;
    for (int i = 0; i < 4; i++) begin
      ccmd[i] = C_NOP;
      if (state == SNOOP && !id_mask[i] && !ack_seen[i]) begin
        ccmd[i] = (cmd == M_WR_BROAD) ? C_WR_SNOOP : C_RD_SNOOP;
      end else if (state == ENABLE && id_mask[i]) begin
        ccmd[i] = (cmd == M_WR_BROAD) ? C_EN_WR : C_EN_RD;
      end
    end
  end

  assign {mbus_ack3_o, mbus_ack2_o, mbus_ack1_o, mbus_ack0_o} = mack;
  assign cbus_cmd0_o = ccmd[0];
  assign cbus_cmd1_o = ccmd[1];
  assign cbus_cmd2_o = ccmd[2];
  assign cbus_cmd3_o = ccmd[3];
  assign cbus_addr_o = (state == IDLE) ? '0 : addr;
  assign grant_id_o  = (state == IDLE) ? 2'd0 : id;
  assign busy_o      = (state != IDLE);
  assign err_o       = err;

endmodule
